// File: rtl/eth_rx_frame_controller.sv
// RX frame sequencer for a 64-bit AXI-stream carrying UDP/IPv4 over Ethernet.
// Parses the 6 header beats, accepts or drops each frame against runtime config and forwards payload.
module eth_rx_frame_controller #(
    parameter int          CNT_W     = 32,
    parameter logic [15:0] ETHERTYPE = 16'h0800,
    parameter logic [7:0]  IP_PROTO  = 8'd17
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_axis_tvalid,
    input  logic [63:0]      i_rx_axis_tdata,
    input  logic             i_rx_axis_tlast,
    input  logic [7:0]       i_rx_axis_tkeep,
    input  logic             i_enable,
    input  logic [47:0]      i_cfg_mac,
    input  logic [15:0]      i_cfg_udp_port,
    input  logic             i_cfg_promisc,
    output logic             o_pl_tvalid,
    output logic [63:0]      o_pl_tdata,
    output logic [7:0]       o_pl_tkeep,
    output logic             o_pl_tlast,
    output logic             o_pl_tsof,
    output logic             o_hdr_accept,
    output logic             o_hdr_drop,
    output logic [2:0]       o_drop_reason,
    output logic [CNT_W-1:0] o_frames_ok,
    output logic [CNT_W-1:0] o_frames_drop
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    localparam logic [2:0] RSN_NONE     = 3'd0;
    localparam logic [2:0] RSN_RUNT     = 3'd1;
    localparam logic [2:0] RSN_DISABLED = 3'd2;
    localparam logic [2:0] RSN_MAC      = 3'd3;
    localparam logic [2:0] RSN_ETYPE    = 3'd4;
    localparam logic [2:0] RSN_PROTO    = 3'd5;
    localparam logic [2:0] RSN_PORT     = 3'd6;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [7:0]  IPV4_VIHL = 8'h45;

    logic [1:0]  state;
    logic [2:0]  beat_cnt;
    logic        enable_q;
    logic [15:0] udp_port_q;
    logic        mac_ok;
    logic        etype_ok;
    logic        proto_ok;
    logic        port_ok;

    // Lanes 4..5 carry the EtherType on beat 1 and the UDP destination port on beat 4.
    logic [47:0] dst_mac;
    logic [15:0] lane45;
    logic        mac_hit;
    logic        etype_hit;
    logic        proto_hit;
    logic        port_hit;
    logic        short_last;
    logic [2:0]  hdr_reason;

    assign dst_mac = {i_rx_axis_tdata[7:0],   i_rx_axis_tdata[15:8],
                      i_rx_axis_tdata[23:16], i_rx_axis_tdata[31:24],
                      i_rx_axis_tdata[39:32], i_rx_axis_tdata[47:40]};
    assign lane45  = {i_rx_axis_tdata[39:32], i_rx_axis_tdata[47:40]};

    assign mac_hit    = i_cfg_promisc || (dst_mac == i_cfg_mac) || (dst_mac == BCAST_MAC);
    assign etype_hit  = (lane45 == ETHERTYPE) && (i_rx_axis_tdata[55:48] == IPV4_VIHL);
    assign proto_hit  = (i_rx_axis_tdata[63:56] == IP_PROTO);
    assign port_hit   = (lane45 == udp_port_q);
    assign short_last = i_rx_axis_tlast && (i_rx_axis_tkeep[1:0] != 2'b11);

    // Verdict on the decision beat, lowest-numbered failing reason wins.
    always_comb begin
        // NOTE: default first so every path assigns hdr_reason and no latch is inferred.
        hdr_reason = RSN_NONE;
        if (short_last) begin
            hdr_reason = RSN_RUNT;
        end else if (!enable_q) begin
            hdr_reason = RSN_DISABLED;
        end else if (!mac_ok) begin
            hdr_reason = RSN_MAC;
        end else if (!etype_ok) begin
            hdr_reason = RSN_ETYPE;
        end else if (!proto_ok) begin
            hdr_reason = RSN_PROTO;
        end else if (!port_ok) begin
            hdr_reason = RSN_PORT;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            state         <= ST_IDLE;
            beat_cnt      <= 3'd0;
            enable_q      <= 1'b0;
            udp_port_q    <= 16'd0;
            mac_ok        <= 1'b0;
            etype_ok      <= 1'b0;
            proto_ok      <= 1'b0;
            port_ok       <= 1'b0;
            o_pl_tvalid   <= 1'b0;
            o_pl_tdata    <= 64'd0;
            o_pl_tkeep    <= 8'd0;
            o_pl_tlast    <= 1'b0;
            o_pl_tsof     <= 1'b0;
            o_hdr_accept  <= 1'b0;
            o_hdr_drop    <= 1'b0;
            o_drop_reason <= RSN_NONE;
            o_frames_ok   <= '0;
            o_frames_drop <= '0;
        end else begin
            o_pl_tvalid   <= 1'b0;
            o_pl_tdata    <= 64'd0;
            o_pl_tkeep    <= 8'd0;
            o_pl_tlast    <= 1'b0;
            o_pl_tsof     <= 1'b0;
            o_hdr_accept  <= 1'b0;
            o_hdr_drop    <= 1'b0;
            o_drop_reason <= RSN_NONE;

            if (i_rx_axis_tvalid) begin
                case (state)
                    ST_IDLE: begin
                        enable_q   <= i_enable;
                        udp_port_q <= i_cfg_udp_port;
                        mac_ok     <= mac_hit;
                        if (i_rx_axis_tlast) begin
                            o_hdr_drop    <= 1'b1;
                            o_drop_reason <= RSN_RUNT;
                            o_frames_drop <= o_frames_drop + CNT_W'(1);
                        end else begin
                            state    <= ST_HDR;
                            beat_cnt <= 3'd1;
                        end
                    end

                    ST_HDR: begin
                        case (beat_cnt)
                            3'd1:    etype_ok <= etype_hit;
                            3'd2:    proto_ok <= proto_hit;
                            3'd4:    port_ok  <= port_hit;
                            default: ;
                        endcase

                        if (beat_cnt != 3'd5) begin
                            if (i_rx_axis_tlast) begin
                                o_hdr_drop    <= 1'b1;
                                o_drop_reason <= RSN_RUNT;
                                o_frames_drop <= o_frames_drop + CNT_W'(1);
                                state         <= ST_IDLE;
                                beat_cnt      <= 3'd0;
                            end else begin
                                beat_cnt <= beat_cnt + 3'd1;
                            end
                        end else if (hdr_reason == RSN_NONE) begin
                            // Lanes 0..1 of beat 5 still hold the UDP checksum.
                            o_hdr_accept <= 1'b1;
                            o_frames_ok  <= o_frames_ok + CNT_W'(1);
                            o_pl_tvalid  <= 1'b1;
                            o_pl_tdata   <= i_rx_axis_tdata;
                            o_pl_tkeep   <= {i_rx_axis_tkeep[7:2], 2'b00};
                            o_pl_tlast   <= i_rx_axis_tlast;
                            o_pl_tsof    <= 1'b1;
                            state        <= i_rx_axis_tlast ? ST_IDLE : ST_PAYLOAD;
                            beat_cnt     <= 3'd0;
                        end else begin
                            o_hdr_drop    <= 1'b1;
                            o_drop_reason <= hdr_reason;
                            o_frames_drop <= o_frames_drop + CNT_W'(1);
                            state         <= i_rx_axis_tlast ? ST_IDLE : ST_DROP;
                            beat_cnt      <= 3'd0;
                        end
                    end

                    ST_PAYLOAD: begin
                        o_pl_tvalid <= 1'b1;
                        o_pl_tdata  <= i_rx_axis_tdata;
                        o_pl_tkeep  <= i_rx_axis_tkeep;
                        o_pl_tlast  <= i_rx_axis_tlast;
                        if (i_rx_axis_tlast) begin
                            state <= ST_IDLE;
                        end
                    end

                    ST_DROP: begin
                        if (i_rx_axis_tlast) begin
                            state <= ST_IDLE;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_controller.sv
// Scoreboard bench for eth_rx_frame_controller: a frame model queues expected decisions and
// payload beats as stimulus is driven; a negedge monitor pops and compares them.
module tb_eth_rx_frame_controller;

    localparam int CNT_W = 4;

    localparam logic [2:0] R_NONE     = 3'd0;
    localparam logic [2:0] R_RUNT     = 3'd1;
    localparam logic [2:0] R_DISABLED = 3'd2;
    localparam logic [2:0] R_MAC      = 3'd3;
    localparam logic [2:0] R_ETYPE    = 3'd4;
    localparam logic [2:0] R_PROTO    = 3'd5;
    localparam logic [2:0] R_PORT     = 3'd6;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_rx_axis_tvalid;
    logic [63:0]      i_rx_axis_tdata;
    logic             i_rx_axis_tlast;
    logic [7:0]       i_rx_axis_tkeep;
    logic             i_enable;
    logic [47:0]      i_cfg_mac;
    logic [15:0]      i_cfg_udp_port;
    logic             i_cfg_promisc;
    logic             o_pl_tvalid;
    logic [63:0]      o_pl_tdata;
    logic [7:0]       o_pl_tkeep;
    logic             o_pl_tlast;
    logic             o_pl_tsof;
    logic             o_hdr_accept;
    logic             o_hdr_drop;
    logic [2:0]       o_drop_reason;
    logic [CNT_W-1:0] o_frames_ok;
    logic [CNT_W-1:0] o_frames_drop;

    always #5 clk = ~clk;

    eth_rx_frame_controller #(.CNT_W(CNT_W)) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_rx_axis_tvalid (i_rx_axis_tvalid),
        .i_rx_axis_tdata  (i_rx_axis_tdata),
        .i_rx_axis_tlast  (i_rx_axis_tlast),
        .i_rx_axis_tkeep  (i_rx_axis_tkeep),
        .i_enable         (i_enable),
        .i_cfg_mac        (i_cfg_mac),
        .i_cfg_udp_port   (i_cfg_udp_port),
        .i_cfg_promisc    (i_cfg_promisc),
        .o_pl_tvalid      (o_pl_tvalid),
        .o_pl_tdata       (o_pl_tdata),
        .o_pl_tkeep       (o_pl_tkeep),
        .o_pl_tlast       (o_pl_tlast),
        .o_pl_tsof        (o_pl_tsof),
        .o_hdr_accept     (o_hdr_accept),
        .o_hdr_drop       (o_hdr_drop),
        .o_drop_reason    (o_drop_reason),
        .o_frames_ok      (o_frames_ok),
        .o_frames_drop    (o_frames_drop)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        sof;
        int          cyc;
    } pl_exp_t;

    typedef struct {
        logic             acc;
        logic [2:0]       reason;
        int               cyc;
        logic [CNT_W-1:0] ok;
        logic [CNT_W-1:0] drop;
    } dec_exp_t;

    pl_exp_t  pl_q[$];
    dec_exp_t dec_q[$];
    pl_exp_t  mon_pl;
    dec_exp_t mon_dec;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic             cfg_en;
    logic [47:0]      cfg_mac;
    logic [15:0]      cfg_port;
    logic             cfg_promisc;
    logic [CNT_W-1:0] exp_ok;
    logic [CNT_W-1:0] exp_drop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Config is only meaningful on beat 0; later beats see it inverted to prove it was latched.
    task automatic drive_cfg(input logic first);
        i_enable       = first ? cfg_en      : ~cfg_en;
        i_cfg_mac      = first ? cfg_mac     : ~cfg_mac;
        i_cfg_udp_port = first ? cfg_port    : ~cfg_port;
        i_cfg_promisc  = first ? cfg_promisc : ~cfg_promisc;
    endtask

    task automatic idle(input int n);
        i_rx_axis_tvalid = 1'b0;
        repeat (n) step();
    endtask

    task automatic apply_reset();
        i_rx_axis_tvalid = 1'b0;
        i_reset          = 1'b1;
        step();
        check("rst_pl_tvalid",   64'(o_pl_tvalid),   64'd0);
        check("rst_pl_tdata",    64'(o_pl_tdata),    64'd0);
        check("rst_pl_tkeep",    64'(o_pl_tkeep),    64'd0);
        check("rst_pl_tlast",    64'(o_pl_tlast),    64'd0);
        check("rst_pl_tsof",     64'(o_pl_tsof),     64'd0);
        check("rst_hdr_accept",  64'(o_hdr_accept),  64'd0);
        check("rst_hdr_drop",    64'(o_hdr_drop),    64'd0);
        check("rst_drop_reason", 64'(o_drop_reason), 64'd0);
        check("rst_frames_ok",   64'(o_frames_ok),   64'd0);
        check("rst_frames_drop", 64'(o_frames_drop), 64'd0);
        step();
        i_reset  = 1'b0;
        exp_ok   = '0;
        exp_drop = '0;
        check("rst_pl_q_empty",  64'(pl_q.size()),  64'd0);
        check("rst_dec_q_empty", 64'(dec_q.size()), 64'd0);
    endtask

    function automatic logic [2:0] model_reason(input logic [47:0] dst, input logic [15:0] etype,
                                                input logic [7:0] ver, input logic [7:0] proto,
                                                input logic [15:0] port, input int nbytes);
        if (nbytes < 42) return R_RUNT;
        if (!cfg_en) return R_DISABLED;
        if (!(cfg_promisc || dst == cfg_mac || dst == 48'hFFFF_FFFF_FFFF)) return R_MAC;
        if (etype != 16'h0800 || ver != 8'h45) return R_ETYPE;
        if (proto != 8'd17) return R_PROTO;
        if (port != cfg_port) return R_PORT;
        return R_NONE;
    endfunction

    // Drives one frame of nbytes bytes; abort_beat >= 0 resets the DUT right after that beat.
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input logic [7:0] ver,
                              input logic [7:0] proto, input logic [15:0] port, input int nbytes,
                              input int max_gap, input int abort_beat);
        logic [7:0]  fb [0:255];
        logic [63:0] data;
        logic [7:0]  keep;
        logic [2:0]  reason;
        int          nbeats;
        int          dec_beat;
        int          rem;
        pl_exp_t     pe;
        dec_exp_t    de;
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) fb[i] = dst[47-8*i -: 8];
        fb[12] = etype[15:8];
        fb[13] = etype[7:0];
        fb[14] = ver;
        fb[23] = proto;
        fb[36] = port[15:8];
        fb[37] = port[7:0];
        nbeats   = (nbytes + 7) / 8;
        dec_beat = (nbeats >= 6) ? 5 : nbeats - 1;
        reason   = model_reason(dst, etype, ver, proto, port, nbytes);

        for (int b = 0; b < nbeats; b++) begin
            if (b > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    i_rx_axis_tvalid = 1'b0;
                    i_rx_axis_tdata  = {$urandom, $urandom};
                    i_rx_axis_tlast  = 1'($urandom_range(0, 1));
                    drive_cfg(1'b0);
                    step();
                end
            end
            for (int j = 0; j < 8; j++) data[8*j +: 8] = fb[8*b + j];
            rem  = nbytes - 8 * b;
            keep = (rem >= 8) ? 8'hFF : 8'((9'd1 << rem) - 9'd1);
            i_rx_axis_tvalid = 1'b1;
            i_rx_axis_tdata  = data;
            i_rx_axis_tkeep  = keep;
            i_rx_axis_tlast  = (b == nbeats - 1);
            drive_cfg(b == 0);
            if (b == dec_beat) begin
                de.acc = (reason == R_NONE);
                if (de.acc) exp_ok = exp_ok + CNT_W'(1);
                else        exp_drop = exp_drop + CNT_W'(1);
                de.reason = reason;
                de.cyc    = cyc + 1;
                de.ok     = exp_ok;
                de.drop   = exp_drop;
                dec_q.push_back(de);
            end
            if (reason == R_NONE && b >= 5) begin
                pe.data = data;
                pe.keep = (b == 5) ? {keep[7:2], 2'b00} : keep;
                pe.last = (b == nbeats - 1);
                pe.sof  = (b == 5);
                pe.cyc  = cyc + 1;
                pl_q.push_back(pe);
            end
            step();
            if (b == abort_beat) begin
                apply_reset();
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_pl_tvalid === 1'b1) begin
            if (pl_q.size() == 0) begin
                check("pl_unexpected", 64'd1, 64'd0);
            end else begin
                mon_pl = pl_q.pop_front();
                check("pl_cycle", 64'(cyc),        64'(mon_pl.cyc));
                check("pl_tdata", o_pl_tdata,      mon_pl.data);
                check("pl_tkeep", 64'(o_pl_tkeep), 64'(mon_pl.keep));
                check("pl_tlast", 64'(o_pl_tlast), 64'(mon_pl.last));
                check("pl_tsof",  64'(o_pl_tsof),  64'(mon_pl.sof));
            end
        end
        if (o_hdr_accept === 1'b1 || o_hdr_drop === 1'b1) begin
            if (dec_q.size() == 0) begin
                check("dec_unexpected", 64'd1, 64'd0);
            end else begin
                mon_dec = dec_q.pop_front();
                check("dec_cycle",   64'(cyc),           64'(mon_dec.cyc));
                check("dec_accept",  64'(o_hdr_accept),  64'(mon_dec.acc));
                check("dec_drop",    64'(o_hdr_drop),    64'(!mon_dec.acc));
                check("dec_reason",  64'(o_drop_reason), 64'(mon_dec.reason));
                check("frames_ok",   64'(o_frames_ok),   64'(mon_dec.ok));
                check("frames_drop", 64'(o_frames_drop), 64'(mon_dec.drop));
            end
        end else if (o_drop_reason !== 3'd0 && i_reset === 1'b0 && cyc > 3) begin
            check("reason_idle", 64'(o_drop_reason), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset          = 1'b1;
        i_rx_axis_tvalid = 1'b0;
        i_rx_axis_tdata  = 64'd0;
        i_rx_axis_tlast  = 1'b0;
        i_rx_axis_tkeep  = 8'd0;
        cfg_en      = 1'b1;
        cfg_mac     = 48'h02_11_22_33_44_55;
        cfg_port    = 16'd5000;
        cfg_promisc = 1'b0;
        exp_ok      = '0;
        exp_drop    = '0;
        drive_cfg(1'b1);
        step();
        apply_reset();
        idle(2);

        // Directed: accept, port miss, runt recovery, priority and address modes, back to back.
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 72, 0, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port + 16'd1, 72, 0, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 32, 0, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 72, 0, -1);
        cfg_en = 1'b0;
        send_frame(48'h0A_0B_0C_0D_0E_0F, 16'h0800, 8'h45, 8'd17, cfg_port, 72, 0, -1);
        cfg_en = 1'b1;
        send_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'd17, cfg_port, 80, 0, -1);
        cfg_promisc = 1'b1;
        send_frame(48'h0A_0B_0C_0D_0E_0F, 16'h0800, 8'h45, 8'd17, cfg_port, 64, 0, -1);
        cfg_promisc = 1'b0;
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 42, 0, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 41, 0, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 40, 0, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 8, 0, -1);
        send_frame(48'h0A_0B_0C_0D_0E_0F, 16'h0800, 8'h45, 8'd17, cfg_port, 72, 0, -1);
        send_frame(cfg_mac, 16'h86DD, 8'h45, 8'd17, cfg_port, 72, 0, -1);
        send_frame(cfg_mac, 16'h0800, 8'h46, 8'd17, cfg_port, 72, 0, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd6, cfg_port, 72, 0, -1);
        idle(3);

        // Gaps inside header and payload, then a reset in the middle of a payload.
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 100, 3, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port ^ 16'h0001, 100, 3, -1);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 120, 3, 8);
        send_frame(cfg_mac, 16'h0800, 8'h45, 8'd17, cfg_port, 64, 0, -1);
        idle(2);

        // Mixed random traffic; the narrow counters wrap along the way.
        for (int it = 0; it < 40; it++) begin
            int          kind;
            int          len;
            logic [47:0] d;
            logic [15:0] et;
            logic [7:0]  vr;
            logic [7:0]  pr;
            logic [15:0] pt;
            cfg_en      = ($urandom_range(0, 7) != 0);
            cfg_promisc = ($urandom_range(0, 3) == 0);
            kind = $urandom_range(0, 7);
            len  = $urandom_range(42, 130);
            d    = cfg_mac;
            et   = 16'h0800;
            vr   = 8'h45;
            pr   = 8'd17;
            pt   = cfg_port;
            case (kind)
                1: d   = cfg_mac ^ 48'h1;
                2: et  = 16'h0806;
                3: vr  = 8'h46;
                4: pr  = 8'd6;
                5: pt  = cfg_port ^ 16'h0100;
                6: len = $urandom_range(1, 41);
                7: d   = 48'hFFFF_FFFF_FFFF;
                default: ;
            endcase
            send_frame(d, et, vr, pr, pt, len, $urandom_range(0, 2), -1);
        end
        idle(5);

        check("end_pl_q_empty",  64'(pl_q.size()),  64'd0);
        check("end_dec_q_empty", 64'(dec_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
